// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / RAW hazard controller with shift scoreboard and stall counter
module hazard_ctrl #(
    parameter int FWD_EN = 1,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idValid,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idRsValid,
    input  logic             idRtValid,
    input  logic [REG_W-1:0] idWriteReg,
    input  logic             idWriteRegValid,
    input  logic             idIsLoad,
    input  logic             flush,
    input  logic             memStall,
    output logic             stall,
    output logic             freeze,
    output logic             exValid,
    output logic [REG_W-1:0] exWriteReg,
    output logic [CNT_W-1:0] stallCnt
);

    // Scoreboard slots. The WB slot is not stored: the register file writes
    // through, so a writer in WB can never hazard and nothing else reads it.
    // Only the EX slot needs the load flag (load-use is detected in EX only).
    logic             ex_v;
    logic [REG_W-1:0] ex_reg;
    logic             ex_ld;
    logic             mem_v;
    logic [REG_W-1:0] mem_reg;

    logic match_ex;
    logic match_mem;
    logic hazard;
    logic insert_bubble;

    // RAW comparison of decode sources against the in-flight writers
    always_comb begin
        match_ex  = ex_v  & ((idRsValid & (idRs == ex_reg))  | (idRtValid & (idRt == ex_reg)));
        match_mem = mem_v & ((idRsValid & (idRs == mem_reg)) | (idRtValid & (idRt == mem_reg)));
        if (FWD_EN != 0) begin
            hazard = match_ex & ex_ld;
        end else begin
            hazard = match_ex | match_mem;
        end
        // flush kills the ID instruction, so it never needs to wait; a frozen
        // pipe cannot advance anyway, so stall is reasserted once it thaws
        stall         = idValid & hazard & ~flush & ~memStall;
        freeze        = memStall;
        insert_bubble = flush | stall | ~idValid;
    end

    assign exValid    = ex_v;
    assign exWriteReg = ex_reg;

    // Advance the scoreboard and stall counter unless the memory freezes the pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v     <= 1'b0;
            ex_reg   <= '0;
            ex_ld    <= 1'b0;
            mem_v    <= 1'b0;
            mem_reg  <= '0;
            stallCnt <= '0;
        end else if (!memStall) begin
            mem_v   <= ex_v;
            mem_reg <= ex_reg;
            if (insert_bubble) begin
                ex_v   <= 1'b0;
                ex_reg <= '0;
                ex_ld  <= 1'b0;
            end else begin
                // invalid entries are kept clean so a stale specifier never matches
                ex_v   <= idWriteRegValid;
                ex_reg <= idWriteRegValid ? idWriteReg : '0;
                ex_ld  <= idWriteRegValid & idIsLoad;
            end
            if (stall && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl (forwarding and non-forwarding builds)
module tb_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [2:0] rs;
        logic       rsv;
        logic [2:0] rt;
        logic       rtv;
        logic [2:0] wr;
        logic       wrv;
        logic       ld;
        logic       fl;
        logic       ms;
    } in_t;

    typedef struct {
        int          dut;
        logic        stall;
        logic        freeze;
        logic        exv;
        logic [2:0]  exreg;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  in_a = '0;
    in_t  in_b = '0;

    logic        a_stall, a_freeze, a_exv;
    logic [2:0]  a_exreg;
    logic [1:0]  a_cnt;
    logic        b_stall, b_freeze, b_exv;
    logic [2:0]  b_exreg;
    logic [15:0] b_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(1), .REG_W(3), .CNT_W(2)) u_fwd (
        .clk(clk), .rst(rst),
        .idValid(in_a.v), .idRs(in_a.rs), .idRt(in_a.rt),
        .idRsValid(in_a.rsv), .idRtValid(in_a.rtv),
        .idWriteReg(in_a.wr), .idWriteRegValid(in_a.wrv), .idIsLoad(in_a.ld),
        .flush(in_a.fl), .memStall(in_a.ms),
        .stall(a_stall), .freeze(a_freeze), .exValid(a_exv),
        .exWriteReg(a_exreg), .stallCnt(a_cnt)
    );

    hazard_ctrl #(.FWD_EN(0), .REG_W(3), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst),
        .idValid(in_b.v), .idRs(in_b.rs), .idRt(in_b.rt),
        .idRsValid(in_b.rsv), .idRtValid(in_b.rtv),
        .idWriteReg(in_b.wr), .idWriteRegValid(in_b.wrv), .idIsLoad(in_b.ld),
        .flush(in_b.fl), .memStall(in_b.ms),
        .stall(b_stall), .freeze(b_freeze), .exValid(b_exv),
        .exWriteReg(b_exreg), .stallCnt(b_cnt)
    );

    function automatic in_t op(logic [2:0] rs, logic rsv, logic [2:0] rt, logic rtv,
                               logic [2:0] wr, logic wrv, logic ld, logic fl, logic ms);
        in_t x;
        x.v = 1'b1; x.rs = rs; x.rsv = rsv; x.rt = rt; x.rtv = rtv;
        x.wr = wr; x.wrv = wrv; x.ld = ld; x.fl = fl; x.ms = ms;
        return x;
    endfunction

    task automatic chk(string tag, string what, logic [15:0] obs, logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
        end
    endtask

    // Drive one instance, queue its expected outputs, compare on the falling edge, then clock.
    task automatic step(int k, in_t x, logic es, logic ev, logic [2:0] er, logic [15:0] ec, string tag);
        exp_t e;
        exp_t got;
        if (k == 0) begin in_a = x; in_b = '0; end
        else        begin in_b = x; in_a = '0; end
        e.dut = k; e.stall = es; e.freeze = x.ms; e.exv = ev;
        e.exreg = er; e.cnt = ec; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            got = exp_q.pop_front();
            if (got.dut == 0) begin
                chk(got.tag, "stall",  {15'd0, a_stall},  {15'd0, got.stall});
                chk(got.tag, "freeze", {15'd0, a_freeze}, {15'd0, got.freeze});
                chk(got.tag, "exValid", {15'd0, a_exv},   {15'd0, got.exv});
                chk(got.tag, "exWriteReg", {13'd0, a_exreg}, {13'd0, got.exreg});
                chk(got.tag, "stallCnt", {14'd0, a_cnt},  got.cnt);
            end else begin
                chk(got.tag, "stall",  {15'd0, b_stall},  {15'd0, got.stall});
                chk(got.tag, "freeze", {15'd0, b_freeze}, {15'd0, got.freeze});
                chk(got.tag, "exValid", {15'd0, b_exv},   {15'd0, got.exv});
                chk(got.tag, "exWriteReg", {13'd0, b_exreg}, {13'd0, got.exreg});
                chk(got.tag, "stallCnt", b_cnt, got.cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t ld2, use2, ldr7, use7, use3b;
        logic [15:0] ec;
        ld2   = op(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        use2  = op(3'd2, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        ldr7  = op(3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        use7  = op(3'd7, 1'b1, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        use3b = op(3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset two cycles, then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, '0, 1'b0, 1'b0, 3'd0, 16'd0, "t1_fwd");
        step(1, '0, 1'b0, 1'b0, 3'd0, 16'd0, "t1_nofwd");

        // load-use with forwarding: one stall cycle
        step(0, ld2,  1'b0, 1'b0, 3'd0, 16'd0, "t2_ld");
        step(0, use2, 1'b1, 1'b1, 3'd2, 16'd0, "t2_use");
        step(0, use2, 1'b0, 1'b0, 3'd0, 16'd1, "t2_release");
        step(0, '0,   1'b0, 1'b1, 3'd5, 16'd1, "t2_after");

        // ALU producer with forwarding: no stall
        step(0, op(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 3'd0, 16'd1, "t3_addi");
        step(0, op(3'd0, 1'b0, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, 3'd3, 16'd1, "t3_fwd");
        step(0, '0, 1'b0, 1'b1, 3'd1, 16'd1, "t3_after");

        // ALU producer without forwarding: stall while in EX and MEM, not WB
        step(1, op(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 3'd0, 16'd0, "t3b_addi");
        step(1, use3b, 1'b1, 1'b1, 3'd3, 16'd0, "t3b_ex");
        step(1, use3b, 1'b1, 1'b0, 3'd0, 16'd1, "t3b_mem");
        step(1, use3b, 1'b0, 1'b0, 3'd0, 16'd2, "t3b_wb");
        step(1, '0,    1'b0, 1'b1, 3'd6, 16'd2, "t3b_after");

        // flush wins over load-use stall
        step(0, op(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 3'd0, 16'd1, "t4_ld");
        step(0, op(3'd4, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 1'b1, 3'd4, 16'd1, "t4_flush");
        step(0, '0, 1'b0, 1'b0, 3'd0, 16'd1, "t4_after");

        // memory stall freezes the scoreboard, stall resumes after release
        step(0, ld2, 1'b0, 1'b0, 3'd0, 16'd1, "t5_ld");
        for (int i = 0; i < 3; i++) begin
            step(0, op(3'd2, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1, 3'd2, 16'd1, "t5_frozen");
        end
        step(0, use2, 1'b1, 1'b1, 3'd2, 16'd1, "t5_use");
        step(0, use2, 1'b0, 1'b0, 3'd0, 16'd2, "t5_release");
        step(0, '0,   1'b0, 1'b1, 3'd5, 16'd2, "t5_after");

        // saturation of the 2-bit counter over five more stall cycles
        ec = 16'd2;
        for (int i = 0; i < 5; i++) begin
            step(0, ldr7, 1'b0, 1'b0, 3'd0, ec, "t6_ld");
            step(0, use7, 1'b1, 1'b1, 3'd7, ec, "t6_use");
            if (ec != 16'd3) ec = ec + 16'd1;
            step(0, use7, 1'b0, 1'b0, 3'd0, ec, "t6_release");
        end

        // reset while stalled: scoreboard and counter clear, stall drops next cycle
        step(0, ldr7, 1'b0, 1'b0, 3'd0, 16'd3, "t7_ld");
        rst = 1'b1;
        step(0, use7, 1'b1, 1'b1, 3'd7, 16'd3, "t7_rst_stall");
        rst = 1'b0;
        step(0, use7, 1'b0, 1'b0, 3'd0, 16'd0, "t7_after_rst");
        step(0, '0,   1'b0, 1'b0, 3'd0, 16'd0, "t7_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
